// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and shared memory bus for mem_arbiter
interface mem_arbiter_if #(
    parameter int MAW = 8
);
    logic            i_req;
    logic [31:0]     i_addr;
    logic            i_ready;
    logic [31:0]     i_rdata;

    logic            d_req;
    logic            d_we;
    logic [31:0]     d_addr;
    logic [31:0]     d_wdata;
    logic            d_ready;
    logic [31:0]     d_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-cycle shared memory
module mem_arbiter #(
    parameter int MAW          = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            grant_i, grant_d;
    logic            i_ready, d_ready;
    logic [31:0]     i_rdata, d_rdata;
    logic            mem_en, mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [31:0]     mem_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_d   = IDLE;
        starve_d  = starve_q;

        // The completing port is never re-granted, so a busy state only chains the other port.
        case (state_q)
            IDLE: begin
                if (bus.d_req && bus.i_req) begin
                    if (starve_q == LIMIT) grant_i = 1'b1;
                    else                   grant_d = 1'b1;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                i_ready = 1'b1;
                i_rdata = bus.mem_rdata;
                grant_d = bus.d_req;
            end
            BUSY_D: begin
                d_ready = 1'b1;
                d_rdata = bus.d_we ? 32'd0 : bus.mem_rdata;
                grant_i = bus.i_req;
            end
            default: ;
        endcase

        if (!rst) begin
            grant_i = 1'b0;
            grant_d = 1'b0;
            i_ready = 1'b0;
            d_ready = 1'b0;
            i_rdata = '0;
            d_rdata = '0;
        end

        mem_en = grant_i | grant_d;
        if (grant_d) begin
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr[MAW+1:2];
            mem_wdata = bus.d_we ? bus.d_wdata : 32'd0;
            state_d   = BUSY_D;
            if (!bus.i_req)             starve_d = '0;
            else if (starve_q != LIMIT) starve_d = starve_q + SW'(1);
        end else if (grant_i) begin
            mem_addr  = bus.i_addr[MAW+1:2];
            state_d   = BUSY_I;
            starve_d  = '0;
        end
    end

    assign bus.i_ready   = i_ready;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_ready   = d_ready;
    assign bus.d_rdata   = d_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    // Byte-offset and high address bits are not used by the word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[31:MAW+2], bus.i_addr[1:0],
                                bus.d_addr[31:MAW+2], bus.d_addr[1:0]};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a starvation limit of 1
module tb_mem_arbiter;
    localparam int MAW = 8;
    localparam int SL  = 1;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   fails   = 0;

    mem_arbiter_if #(.MAW(MAW)) bus ();

    mem_arbiter #(.MAW(MAW), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic en, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, ".en"},    32'(bus.mem_en),    32'(en));
        chk({tag, ".we"},    32'(bus.mem_we),    32'(we));
        chk({tag, ".addr"},  32'(bus.mem_addr),  addr);
        chk({tag, ".wdata"}, bus.mem_wdata,      wdata);
    endtask

    initial begin
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h54; bus.d_wdata = 32'h7;
        bus.mem_rdata = 32'hFFFF_FFFF;

        // Reset held with requests pending: everything quiet
        @(negedge clk); #1;
        chk_grant("rst", 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst.i_ready", 32'(bus.i_ready), 32'h0);
        chk("rst.d_ready", 32'(bus.d_ready), 32'h0);
        chk("rst.i_rdata", bus.i_rdata, 32'h0);
        chk("rst.d_rdata", bus.d_rdata, 32'h0);

        // Released, no requests
        @(negedge clk); rst = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
        chk_grant("idle", 1'b0, 1'b0, 32'h0, 32'h0);

        // Fetch only at 0x10
        @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.mem_rdata = 32'h0; #1;
        chk_grant("f.c0", 1'b1, 1'b0, 32'h04, 32'h0);
        chk("f.c0.i_ready", 32'(bus.i_ready), 32'h0);
        @(negedge clk); bus.mem_rdata = 32'h2002_0005; #1;
        chk("f.c1.i_ready", 32'(bus.i_ready), 32'h1);
        chk("f.c1.i_rdata", bus.i_rdata, 32'h2002_0005);
        chk("f.c1.no_regrant", 32'(bus.mem_en), 32'h0);
        @(negedge clk); bus.mem_rdata = 32'h0; #1;
        chk_grant("f.c2", 1'b1, 1'b0, 32'h04, 32'h0);
        chk("f.c2.i_rdata", bus.i_rdata, 32'h0);
        @(negedge clk); #1;
        chk("f.c3.i_ready", 32'(bus.i_ready), 32'h1);
        @(negedge clk); bus.i_req = 1'b0; #1;
        chk_grant("f.c4", 1'b0, 1'b0, 32'h0, 32'h0);

        // Store 0x54 with a simultaneous fetch
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h54; bus.d_wdata = 32'h7;
        bus.i_req = 1'b1; bus.i_addr = 32'h10; #1;
        chk_grant("st.c0", 1'b1, 1'b1, 32'h15, 32'h7);
        @(negedge clk); bus.mem_rdata = 32'h1234_5678; #1;
        chk("st.c1.d_ready", 32'(bus.d_ready), 32'h1);
        chk("st.c1.d_rdata", bus.d_rdata, 32'h0);
        chk_grant("st.c1", 1'b1, 1'b0, 32'h04, 32'h0);
        @(negedge clk); bus.d_req = 1'b0; bus.mem_rdata = 32'hCAFE_0001; #1;
        chk("st.c2.i_ready", 32'(bus.i_ready), 32'h1);
        chk("st.c2.i_rdata", bus.i_rdata, 32'hCAFE_0001);
        chk("st.c2.d_ready", 32'(bus.d_ready), 32'h0);
        chk("st.c2.mem_en", 32'(bus.mem_en), 32'h0);

        // Both held: D, I, D, I ... by chaining
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30; bus.mem_rdata = 32'h0; #1;
        chk_grant("alt.d0", 1'b1, 1'b0, 32'h0C, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus.mem_rdata = 32'hA000_0000 + 32'(k); #1;
            chk("alt.d_ready", 32'(bus.d_ready), 32'h1);
            chk("alt.d_rdata", bus.d_rdata, 32'hA000_0000 + 32'(k));
            chk_grant("alt.i", 1'b1, 1'b0, 32'h08, 32'h0);
            @(negedge clk); bus.mem_rdata = 32'hB000_0000 + 32'(k); #1;
            chk("alt.i_ready", 32'(bus.i_ready), 32'h1);
            chk("alt.i_rdata", bus.i_rdata, 32'hB000_0000 + 32'(k));
            chk_grant("alt.d", 1'b1, 1'b0, 32'h0C, 32'h0);
        end
        // Last data completes with no fetch pending; data itself is not re-granted
        @(negedge clk); bus.i_req = 1'b0; #1;
        chk("alt.end.d_ready", 32'(bus.d_ready), 32'h1);
        chk("alt.end.mem_en", 32'(bus.mem_en), 32'h0);

        // Starve count is at the limit: fetch beats data in IDLE
        @(negedge clk); bus.i_req = 1'b1; #1;
        chk_grant("starve", 1'b1, 1'b0, 32'h08, 32'h0);
        @(negedge clk); #1;
        chk("starve.i_ready", 32'(bus.i_ready), 32'h1);
        chk_grant("starve.chain", 1'b1, 1'b0, 32'h0C, 32'h0);

        // Reset during BUSY_D abandons the load; re-granted right after release
        @(negedge clk); rst = 1'b0; bus.i_req = 1'b0; bus.mem_rdata = 32'h5555_5555; #1;
        chk("rbd.d_ready", 32'(bus.d_ready), 32'h0);
        chk("rbd.d_rdata", bus.d_rdata, 32'h0);
        chk_grant("rbd", 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); rst = 1'b1; #1;
        chk("rbd.after.d_ready", 32'(bus.d_ready), 32'h0);
        chk_grant("rbd.after", 1'b1, 1'b0, 32'h0C, 32'h0);
        @(negedge clk); bus.mem_rdata = 32'h0000_0011; #1;
        chk("rbd.done.d_rdata", bus.d_rdata, 32'h0000_0011);

        // Top-of-memory load
        @(negedge clk); bus.d_addr = 32'h3FC; bus.mem_rdata = 32'h0; #1;
        chk_grant("top", 1'b1, 1'b0, 32'hFF, 32'h0);
        @(negedge clk); bus.mem_rdata = 32'hDEAD_BEEF; #1;
        chk("top.d_ready", 32'(bus.d_ready), 32'h1);
        chk("top.d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        @(negedge clk); bus.d_req = 1'b0; #1;
        chk("top.after.d_ready", 32'(bus.d_ready), 32'h0);
        chk("top.after.d_rdata", bus.d_rdata, 32'h0);
        chk_grant("top.after", 1'b0, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
